// File: rtl/rtx_timer_scan_pkg.sv
// Shared definitions for the retransmission timer scan block: global time and timer
// widths, RTO bounds, and the clogb2 helper.
package rtx_timer_scan_pkg;

    localparam int TIME_W  = 32;
    localparam int TIMER_W = 16;

    localparam logic [TIMER_W-1:0] RTO_LOW  = 16'd64;
    localparam logic [TIMER_W-1:0] RTO_HIGH = 16'd4000;

    // Ceiling log2, minimum 1 so a two-entry table still gets a 1-bit id.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r++;
                v = v >> 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rtx_timer_scan_entry.sv
// One flow's timer slot: active flag plus wrap-safe deadline, armed/cancelled/cleared
// by the scan top and reporting whether its deadline has been reached.
module rtx_timer_entry
    import rtx_timer_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TIME_W-1:0]  now,
    input  logic               arm,
    input  logic [TIMER_W-1:0] arm_amnt,
    input  logic               cancel,
    input  logic               clear,
    output logic               expired
);

    logic                     active;
    logic [TIME_W-1:0]        deadline;
    logic signed [TIME_W-1:0] elapsed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            deadline <= '0;
        end else if (arm) begin
            active   <= 1'b1;
            deadline <= now + TIME_W'(arm_amnt);
        end else if (cancel || clear) begin
            active <= 1'b0;
        end
    end

    // A non-negative signed distance means now is at or past the deadline, across wrap.
    assign elapsed = $signed(now - deadline);
    assign expired = active && (elapsed >= 0);

endmodule

// File: rtl/rtx_timer_scan.sv
// Per-flow retransmission timer table with a round-robin expiry scan and a one-deep
// timeout event register. Optional accepted-event counter: RTX_TIMER_FIRE_CNT_EN.
module rtx_timer_scan
    import rtx_timer_scan_pkg::*;
#(
    parameter int FLOW_NUM  = 16,
    parameter int FLOW_ID_W = clogb2(FLOW_NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TIME_W-1:0]    now,
    input  logic                 arm_valid,
    input  logic [FLOW_ID_W-1:0] arm_flow_id,
    input  logic [TIMER_W-1:0]   arm_amnt,
    input  logic                 cancel_valid,
    input  logic [FLOW_ID_W-1:0] cancel_flow_id,
    output logic                 to_valid,
    output logic [FLOW_ID_W-1:0] to_flow_id,
    input  logic                 to_ready
`ifdef RTX_TIMER_FIRE_CNT_EN
    ,
    output logic [31:0]          fire_cnt
`endif
);

    logic [FLOW_NUM-1:0]  expired_vec;
    logic [FLOW_NUM-1:0]  arm_sel;
    logic [FLOW_NUM-1:0]  cancel_sel;
    logic [FLOW_NUM-1:0]  clear_sel;
    logic [FLOW_ID_W-1:0] ptr_p0;
    logic                 stall;
    logic                 ptr_touched;
    logic                 hit;

    assign stall = to_valid && !to_ready;

    // An arm or cancel aimed at the scanned flow overrides that cycle's hit.
    assign ptr_touched = (arm_valid && (arm_flow_id == ptr_p0)) ||
                         (cancel_valid && (cancel_flow_id == ptr_p0));
    assign hit         = !stall && expired_vec[ptr_p0] && !ptr_touched;

    always_comb begin
        arm_sel                 = '0;
        cancel_sel              = '0;
        clear_sel               = '0;
        arm_sel[arm_flow_id]    = arm_valid;
        cancel_sel[cancel_flow_id] = cancel_valid;
        clear_sel[ptr_p0]       = hit;
    end

    for (genvar i = 0; i < FLOW_NUM; i++) begin : g_entry
        rtx_timer_entry u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .now      (now),
            .arm      (arm_sel[i]),
            .arm_amnt (arm_amnt),
            .cancel   (cancel_sel[i]),
            .clear    (clear_sel[i]),
            .expired  (expired_vec[i])
        );
    end

    // Stage p0: scan pointer, held while the event register is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_p0 <= '0;
        end else if (!stall) begin
            ptr_p0 <= ptr_p0 + FLOW_ID_W'(1);
        end
    end

    // Stage p1: registered timeout event; a new hit may reload on the accept cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_valid   <= 1'b0;
            to_flow_id <= '0;
        end else if (hit) begin
            to_valid   <= 1'b1;
            to_flow_id <= ptr_p0;
        end else if (to_ready) begin
            to_valid   <= 1'b0;
        end
    end

`ifdef RTX_TIMER_FIRE_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_cnt <= '0;
        end else if (to_valid && to_ready) begin
            fire_cnt <= sat_inc(fire_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_rtx_timer_scan.sv
// Scoreboard bench for rtx_timer_scan: directed scenarios plus randomized arm/cancel/
// re-arm traffic, checked against a per-flow deadline model and an expected-event queue.
`timescale 1ns/1ps
module tb_rtx_timer_scan;
    import rtx_timer_scan_pkg::*;

    localparam int FLOW_NUM  = 16;
    localparam int FLOW_ID_W = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [TIME_W-1:0]    now;
    logic                 arm_valid;
    logic [FLOW_ID_W-1:0] arm_flow_id;
    logic [TIMER_W-1:0]   arm_amnt;
    logic                 cancel_valid;
    logic [FLOW_ID_W-1:0] cancel_flow_id;
    logic                 to_valid;
    logic [FLOW_ID_W-1:0] to_flow_id;
    logic                 to_ready;
`ifdef RTX_TIMER_FIRE_CNT_EN
    logic [31:0]          fire_cnt;
`endif

    always #5 clk = ~clk;

    rtx_timer_scan #(.FLOW_NUM(FLOW_NUM), .FLOW_ID_W(FLOW_ID_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .now            (now),
        .arm_valid      (arm_valid),
        .arm_flow_id    (arm_flow_id),
        .arm_amnt       (arm_amnt),
        .cancel_valid   (cancel_valid),
        .cancel_flow_id (cancel_flow_id),
        .to_valid       (to_valid),
        .to_flow_id     (to_flow_id),
        .to_ready       (to_ready)
`ifdef RTX_TIMER_FIRE_CNT_EN
        ,
        .fire_cnt       (fire_cnt)
`endif
    );

    // Reference model: which flows hold a live timer and when it falls due.
    logic              m_active   [FLOW_NUM];
    logic [TIME_W-1:0] m_deadline [FLOW_NUM];
    int                exp_q[$];
    int                n_chk = 0;
    int                n_pass = 0;
    int                unexp = 0;
    int                acc_cnt = 0;
    int                cyc = 0;
    bit                rand_ready = 1'b0;
    int                mon_f;
    logic [TIME_W-1:0] mon_since;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Monitor: an event is consumed at the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && to_valid && to_ready) begin
            acc_cnt++;
            check(exp_q.size() != 0, "event_expected", longint'(to_flow_id), -1);
            if (exp_q.size() == 0) begin
                unexp++;
            end else begin
                mon_f = exp_q.pop_front();
                check(int'(to_flow_id) == mon_f, "event_flow", longint'(to_flow_id), mon_f);
                mon_since = now - TIME_W'(1) - m_deadline[mon_f];
                check(m_active[mon_f] && !mon_since[TIME_W-1], "event_after_deadline",
                      longint'(now - TIME_W'(1)), longint'(m_deadline[mon_f]));
                m_active[mon_f] = 1'b0;
            end
        end
    end

    task automatic tick();
        logic [TIME_W-1:0] pre;
        pre = now;
        @(posedge clk);
        #1;
        if (cancel_valid && !(arm_valid && arm_flow_id == cancel_flow_id))
            m_active[cancel_flow_id] = 1'b0;
        if (arm_valid) begin
            m_active[arm_flow_id]   = 1'b1;
            m_deadline[arm_flow_id] = pre + TIME_W'(arm_amnt);
        end
        arm_valid    = 1'b0;
        cancel_valid = 1'b0;
        now          = now + TIME_W'(1);
        cyc++;
        if (rand_ready) to_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_arm(input int f, input int a);
        arm_valid   = 1'b1;
        arm_flow_id = FLOW_ID_W'(f);
        arm_amnt    = TIMER_W'(a);
        tick();
    endtask

    task automatic do_cancel(input int f);
        cancel_valid   = 1'b1;
        cancel_flow_id = FLOW_ID_W'(f);
        tick();
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(exp_q.size() == 0, name, exp_q.size(), 0);
        exp_q.delete();
        tick();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        arm_valid    = 1'b0;
        cancel_valid = 1'b0;
        for (int i = 0; i < FLOW_NUM; i++) m_active[i] = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cyc     = 0;
        acc_cnt = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int u0;
        int n;
        int f, a, d, a2, mode;
        now            = '0;
        arm_valid      = 1'b0;
        arm_flow_id    = '0;
        arm_amnt       = '0;
        cancel_valid   = 1'b0;
        cancel_flow_id = '0;
        to_ready       = 1'b1;
        for (int i = 0; i < FLOW_NUM; i++) begin
            m_active[i]   = 1'b0;
            m_deadline[i] = '0;
        end

        do_reset();
        check(to_valid == 1'b0, "reset_to_valid", to_valid, 0);
        check(to_flow_id == '0, "reset_to_flow_id", to_flow_id, 0);
`ifdef RTX_TIMER_FIRE_CNT_EN
        check(fire_cnt == 32'd0, "reset_fire_cnt", fire_cnt, 0);
`endif

        // Flow 3, amount 20 at now=100.
        now = TIME_W'(100);
        do_arm(3, 20);
        exp_q.push_back(3);
        wait_empty(20 + FLOW_NUM + 4, "flow3_event");

        // Deadline that wraps past zero.
        now = TIME_W'(32'hFFFF_FFFC);
        do_arm(5, 10);
        exp_q.push_back(5);
        wait_empty(10 + FLOW_NUM + 4, "wrap_event");

        // Cancel before expiry, then arm+cancel in one cycle.
        u0  = unexp;
        now = TIME_W'(2000);
        do_arm(7, 30);
        idle(5);
        do_cancel(7);
        idle(30 + FLOW_NUM + 8);
        check(unexp == u0, "cancel_no_event", unexp - u0, 0);
        arm_valid      = 1'b1;
        arm_flow_id    = FLOW_ID_W'(7);
        arm_amnt       = TIMER_W'(5);
        cancel_valid   = 1'b1;
        cancel_flow_id = FLOW_ID_W'(7);
        tick();
        exp_q.push_back(7);
        wait_empty(5 + FLOW_NUM + 4, "arm_beats_cancel");

        // Re-arm flow 0 on the exact cycle the scan reaches it expired (ptr 0 at edge 16).
        do_reset();
        now = TIME_W'(500);
        do_arm(0, 0);
        idle(15);
        do_arm(0, 40);
        exp_q.push_back(0);
        wait_empty(40 + FLOW_NUM + 4, "rearm_on_hit");

        // Flows 1,2,4 share deadline 3017, reached when the scan sits on flow 1.
        do_reset();
        to_ready = 1'b0;
        now = TIME_W'(3000);
        do_arm(1, 17);
        do_arm(2, 16);
        do_arm(4, 15);
        idle(15);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(4);
        for (int i = 0; i < 30; i++) begin
            check(to_valid == 1'b1 && to_flow_id == FLOW_ID_W'(1), "hold_stable",
                  longint'({to_valid, to_flow_id}), 17);
            tick();
        end
        to_ready = 1'b1;
        wait_empty(FLOW_NUM + 8, "burst_drain");
        check(acc_cnt == 3, "burst_count", acc_cnt, 3);
`ifdef RTX_TIMER_FIRE_CNT_EN
        check(fire_cnt == 32'd3, "burst_fire_cnt", fire_cnt, 3);
`endif

        // Randomized single-flow traffic with random backpressure.
        rand_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            f    = $urandom_range(0, FLOW_NUM - 1);
            a    = $urandom_range(2, 80);
            mode = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) now = TIME_W'($urandom());
            do_arm(f, a);
            d = $urandom_range(1, a - 1);
            if (mode == 0) begin
                u0 = unexp;
                idle(d - 1);
                do_cancel(f);
                idle(a + FLOW_NUM + 8);
                check(unexp == u0, "rand_cancel", unexp - u0, 0);
            end else if (mode == 1) begin
                idle(d - 1);
                a2 = $urandom_range(2, 80);
                do_arm(f, a2);
                exp_q.push_back(f);
                wait_empty(a2 + FLOW_NUM + 64, "rand_rearm");
            end else begin
                exp_q.push_back(f);
                wait_empty(a + FLOW_NUM + 64, "rand_event");
            end
        end
        rand_ready = 1'b0;
        to_ready   = 1'b1;
        idle(2);

        // Reset while an event is pending and another timer is armed.
        to_ready = 1'b0;
        now = TIME_W'(4000);
        do_arm(9, 2);
        do_arm(10, 50);
        n = 0;
        while (!to_valid && n < FLOW_NUM + 8) begin
            tick();
            n++;
        end
        check(to_valid == 1'b1, "pending_before_reset", to_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check(to_valid == 1'b0, "reset_drops_valid", to_valid, 0);
        check(to_flow_id == '0, "reset_drops_flow_id", to_flow_id, 0);
        do_reset();
`ifdef RTX_TIMER_FIRE_CNT_EN
        check(fire_cnt == 32'd0, "reset_clears_fire_cnt", fire_cnt, 0);
`endif
        to_ready = 1'b1;
        u0 = unexp;
        idle(80);
        check(unexp == u0, "no_event_after_reset", unexp - u0, 0);

        check(unexp == 0, "no_unexpected_total", unexp, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rtx_timer_scan.md
# rtx_timer_scan

Per-flow retransmission timer table that sits directly upstream of the user-defined timeout stage. It holds one deadline per flow and scans flows round-robin, one per cycle. When a flow's deadline has passed, it emits a single timeout event carrying the flow id. The downstream stage then fetches that flow's context and drives `timeout_expired` into the user timeout logic. The new `rtx_timer_amnt_out` from that logic comes back here as an arm request.

## Interface
- `FLOW_NUM`, 16, number of flows tracked; power of two, at least 2.
- `FLOW_ID_W`, `clogb2(FLOW_NUM)`, flow id width.
- Widths `TIME_W` and `TIMER_W` come from the shared global macros.

Ports:
- `clk`  in  1  single clock; reset is asynchronous and active-low (`rst_n`).
- `rst_n`  in  1  asynchronous, active-low reset.
- `now`  in  `TIME_W`  free-running time, wraps modulo 2^`TIME_W`.
- `arm_valid`  in  1  arm or re-arm one flow's timer.
- `arm_flow_id`  in  `FLOW_ID_W`  flow to arm.
- `arm_amnt`  in  `TIMER_W`  timeout amount, relative to `now`.
- `cancel_valid`  in  1  disarm one flow (window fully acked).
- `cancel_flow_id`  in  `FLOW_ID_W`  flow to disarm.
- `to_valid`  out  1  timeout event pending.
- `to_flow_id`  out  `FLOW_ID_W`  expired flow.
- `to_ready`  in  1  downstream accepts the event.
- `fire_cnt`  out  32  total events accepted; present only with `RTX_TIMER_FIRE_CNT_EN`.

## Operation
- Table per flow: `active` (1 bit) and `deadline` (`TIME_W` bits).
- Arm: `deadline <= now + zero_ext(arm_amnt)` modulo 2^`TIME_W`, and `active <= 1`.
- Cancel: `active <= 0`.
- Arm and cancel of the same flow in the same cycle: arm wins.
- Scan pointer `ptr` increments by 1 each non-stalled cycle and wraps from `FLOW_NUM-1` to 0.
- Expiry test: `active[ptr]` and MSB of `(now - deadline[ptr])` equals 0. This means `now` is at or past the deadline, and it stays valid across wrap as long as `arm_amnt` < 2^(`TIME_W`-1).
- On a hit: load `to_flow_id <= ptr`, set `to_valid <= 1`, clear `active[ptr]`.
- If an arm or cancel targets `ptr` in the same cycle as a hit, the arm or cancel wins. No event is raised and `active` follows the arm/cancel.
- Output register is one-deep:
  - While `to_valid && !to_ready`, the scan stalls: `ptr` is held and no compare is committed.
  - Arm and cancel are still accepted while stalled.
- Handshake follows standard valid/ready rules:
  - Once `to_valid` is high, `to_flow_id` stays stable until `to_ready`.
  - On acceptance, a new hit may load in the same cycle, giving back-to-back events.
- Arming a flow whose event is already held in the output register does not retract the event. Downstream treats the event as stale if the context shows it.

## Timing
- Reset (async assert): all `active`=0, `deadline`=0, `ptr`=0, `to_valid`=0, `to_flow_id`=0, `fire_cnt`=0.
- Deassertion of `rst_n` is synchronised externally.
- Arm and cancel take effect at the next clock edge and are visible to the scan compare in the following cycle.
- Compare to `to_valid`: 1 cycle (registered output).
- Worst-case detection latency after expiry: `FLOW_NUM` cycles plus stall cycles.
- Reset mid-event drops the pending event and all armed timers.

## Configuration
- `RTX_TIMER_FIRE_CNT_EN` defined:
  - 32-bit `fire_cnt` port exists.
  - It increments on each `to_valid && to_ready` and saturates at `32'hFFFF_FFFF`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package/header: `TIME_W`, `TIMER_W`, the `RTO_LOW`/`RTO_HIGH` constants, and `clogb2.vh`.
- Sub-module `rtx_timer_entry`: holds one flow's `active` and `deadline`, with arm/cancel/clear inputs and an `expired` output.
  - The top level instantiates `FLOW_NUM` of these, plus the scan pointer and output register.

## Test plan
- Arm flow 3 with amount 20 at `now`=100, `to_ready`=1 → exactly one event, flow 3, within 16 cycles after `now`≥120; none before `now`=120.
- Arm flow 5 with amount 10 at `now`=2^`TIME_W`-4 → event for flow 5 after `now` wraps to 6; no early fire at `now`=2^`TIME_W`-1.
- Arm flows 1, 2, 4 to expire together, hold `to_ready`=0 for 30 cycles → `to_valid` held with flow 1 and stable. After release, events 2 and 4 follow in order and the count is 3.
- Arm flow 7, then cancel before expiry → no event. Arm and cancel flow 7 in the same cycle → armed, event later fires.
- Re-arm flow 0 in the cycle its expiry compare hits → no event; new deadline honoured.
- Assert `rst_n`=0 while `to_valid`=1 → `to_valid`=0 immediately. No events after release until a new arm. `fire_cnt`=0 when `RTX_TIMER_FIRE_CNT_EN` is defined.
